// File: rtl/env_int_ctl.sv
// I/O-programmed interrupt source for the tv80s environment: countdown timers drive int_n (level, acked) and nmi_n (pulse).
// ENV_INT_AUTO_REARM_EN: an intack reloads the last nonzero INT_CNT so interrupts repeat periodically.
module env_int_ctl #(
  parameter logic [7:0]  BASE_ADDR = 8'h90,
  parameter int unsigned NMI_WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       m1_n,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] addr,
  input  logic [7:0] DO,
  output logic [7:0] DI,
  output logic       int_n,
  output logic       nmi_n
);
  typedef enum logic [1:0] {I_IDLE, I_COUNT, I_ASSERT} int_st_t;
  typedef enum logic [1:0] {N_IDLE, N_COUNT, N_PULSE}  nmi_st_t;
  localparam logic [3:0] NMI_W = 4'(NMI_WIDTH);

  int_st_t    r_int_st, w_int_st_nxt;
  nmi_st_t    r_nmi_st, w_nmi_st_nxt;
  logic [7:0] r_int_ld, r_nmi_ld, r_vec;
  logic [7:0] r_int_cnt, w_int_cnt_nxt, r_nmi_cnt, w_nmi_cnt_nxt;
  logic [3:0] r_ack_cnt, w_ack_cnt_nxt, r_nmi_pw, w_nmi_pw_nxt;
  logic       r_nmi_pend, w_nmi_pend_nxt;
  logic       r_wr_d, r_int_n, r_nmi_n;
  logic       w_sel, w_io_wr, w_io_rd, w_intack, w_wr_stb;
  logic       w_wr_int, w_wr_nmi, w_wr_vec, w_wr_stat;
  logic [7:0] w_status, w_rd_data;

  assign w_sel     = (addr[7:2] == BASE_ADDR[7:2]);
  assign w_io_wr   = !iorq_n && !wr_n && m1_n && w_sel;
  assign w_io_rd   = !iorq_n && !rd_n && m1_n && w_sel;
  assign w_intack  = !m1_n && !iorq_n;
  // A strobe held over several clocks must act only once.
  assign w_wr_stb  = w_io_wr && !r_wr_d;
  assign w_wr_int  = w_wr_stb && (addr[1:0] == 2'd0);
  assign w_wr_nmi  = w_wr_stb && (addr[1:0] == 2'd1);
  assign w_wr_vec  = w_wr_stb && (addr[1:0] == 2'd2);
  assign w_wr_stat = w_wr_stb && (addr[1:0] == 2'd3);

  assign w_status = {r_ack_cnt, r_nmi_st == N_COUNT, r_int_st == I_COUNT,
                     r_nmi_st == N_PULSE, r_int_st == I_ASSERT};

  always_comb begin
    w_rd_data = r_int_ld;
    case (addr[1:0])
      2'd1:    w_rd_data = r_nmi_ld;
      2'd2:    w_rd_data = r_vec;
      2'd3:    w_rd_data = w_status;
      default: w_rd_data = r_int_ld;
    endcase
  end

  assign DI = w_io_rd ? w_rd_data :
              (w_intack && r_int_st == I_ASSERT) ? r_vec : 8'hzz;
  assign int_n = r_int_n;
  assign nmi_n = r_nmi_n;

`ifdef ENV_INT_AUTO_REARM_EN
  logic [7:0] r_int_rld;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  r_int_rld <= '0;
    else if (w_wr_int && DO != '0) r_int_rld <= DO;
  end
`endif

  always_comb begin
    w_int_st_nxt  = r_int_st;
    w_int_cnt_nxt = r_int_cnt;
    w_ack_cnt_nxt = r_ack_cnt;
    case (r_int_st)
      I_COUNT: begin
        w_int_cnt_nxt = r_int_cnt - 8'd1;
        if (r_int_cnt <= 8'd1) w_int_st_nxt = I_ASSERT;
      end
      I_ASSERT: begin
        if (w_intack) w_ack_cnt_nxt = r_ack_cnt + 4'd1;
        if (w_wr_stat && DO[0]) w_int_st_nxt = I_IDLE;
        else if (w_intack) begin
`ifdef ENV_INT_AUTO_REARM_EN
          w_int_st_nxt  = I_COUNT;
          w_int_cnt_nxt = r_int_rld;
`else
          w_int_st_nxt  = I_IDLE;
`endif
        end
      end
      default: ;
    endcase
    if (w_wr_stat && DO[4]) w_ack_cnt_nxt = '0;
    if (w_wr_int) begin
      w_int_cnt_nxt = DO;
      w_int_st_nxt  = (DO != '0) ? I_COUNT : I_IDLE;
    end
  end

  always_comb begin
    w_nmi_st_nxt   = r_nmi_st;
    w_nmi_cnt_nxt  = r_nmi_cnt;
    w_nmi_pw_nxt   = r_nmi_pw;
    w_nmi_pend_nxt = r_nmi_pend;
    case (r_nmi_st)
      N_COUNT: begin
        w_nmi_cnt_nxt = r_nmi_cnt - 8'd1;
        if (r_nmi_cnt <= 8'd1) begin
          w_nmi_st_nxt = N_PULSE;
          w_nmi_pw_nxt = NMI_W;
        end
      end
      N_PULSE: begin
        if (r_nmi_pw <= 4'd1) begin
          w_nmi_pend_nxt = 1'b0;
          if (r_nmi_pend) begin
            w_nmi_st_nxt  = N_COUNT;
            w_nmi_cnt_nxt = r_nmi_ld;
          end else begin
            w_nmi_st_nxt  = N_IDLE;
          end
        end else begin
          w_nmi_pw_nxt = r_nmi_pw - 4'd1;
        end
      end
      default: ;
    endcase
    // Mid-pulse writes wait for the pulse to finish; the value sits in r_nmi_ld.
    if (w_wr_nmi) begin
      if (r_nmi_st == N_PULSE && r_nmi_pw > 4'd1) begin
        w_nmi_pend_nxt = (DO != '0);
      end else begin
        w_nmi_pend_nxt = 1'b0;
        w_nmi_cnt_nxt  = DO;
        w_nmi_st_nxt   = (DO != '0) ? N_COUNT : N_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_d     <= 1'b0;
      r_int_ld   <= '0;
      r_nmi_ld   <= '0;
      r_vec      <= 8'hFF;
      r_int_st   <= I_IDLE;
      r_int_cnt  <= '0;
      r_ack_cnt  <= '0;
      r_int_n    <= 1'b1;
      r_nmi_st   <= N_IDLE;
      r_nmi_cnt  <= '0;
      r_nmi_pw   <= '0;
      r_nmi_pend <= 1'b0;
      r_nmi_n    <= 1'b1;
    end else begin
      r_wr_d     <= w_io_wr;
      if (w_wr_int) r_int_ld <= DO;
      if (w_wr_nmi) r_nmi_ld <= DO;
      if (w_wr_vec) r_vec    <= DO;
      r_int_st   <= w_int_st_nxt;
      r_int_cnt  <= w_int_cnt_nxt;
      r_ack_cnt  <= w_ack_cnt_nxt;
      r_int_n    <= (w_int_st_nxt != I_ASSERT);
      r_nmi_st   <= w_nmi_st_nxt;
      r_nmi_cnt  <= w_nmi_cnt_nxt;
      r_nmi_pw   <= w_nmi_pw_nxt;
      r_nmi_pend <= w_nmi_pend_nxt;
      r_nmi_n    <= (w_nmi_st_nxt != N_PULSE);
    end
  end
endmodule

// File: doc/env_int_ctl.md
Name: env_int_ctl

Overview:
- Testbench-side interrupt source for the tv80s environment. It sits on the CPU I/O bus next to env_io and directly drives the core's int_n and nmi_n inputs.
- Software running on the core programs countdown timers through I/O writes. The block then asserts a maskable interrupt (level, held until acknowledged) or a fixed-width NMI pulse.
- During the IM2 interrupt-acknowledge cycle the block supplies the vector byte on the shared DI bus.

Parameters:
- BASE_ADDR, 8'h90, I/O base address; the block decodes 4 consecutive ports BASE_ADDR+0..+3.
- NMI_WIDTH, 4, nmi_n low-pulse width in clk cycles; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- m1_n  input  1  CPU M1 strobe.
- iorq_n  input  1  CPU I/O request.
- rd_n  input  1  CPU read strobe.
- wr_n  input  1  CPU write strobe.
- addr  input  8  CPU address A[7:0].
- DO  input  8  CPU write data.
- DI  output  8  read data / IM2 vector, tri-state (8'hzz) when not driving.
- int_n  output  1  maskable interrupt to core, active low.
- nmi_n  output  1  non-maskable interrupt to core, active low.

Behaviour:
- Reset: asynchronous assert, synchronous release. Outputs int_n=1, nmi_n=1, DI=8'hzz. Registers INT_CNT=0, NMI_CNT=0, VECTOR=8'hFF, ack_cnt=0. Both FSMs go to IDLE.
- io_wr = !iorq_n & !wr_n & m1_n & addr[7:2]==BASE_ADDR[7:2].
  - A write acts once per bus cycle, on the first posedge where io_wr=1 and io_wr was 0 on the previous posedge. The edge detect is a registered copy of io_wr, reset to 0.
- io_rd = !iorq_n & !rd_n & m1_n & address match.
  - DI is combinational from the selected register while io_rd=1.
- intack = !m1_n & !iorq_n.
  - While intack=1 and the INT FSM is in ASSERT, DI=VECTOR. Otherwise DI=8'hzz.
- Register map, by offset:
  - +0 INT_CNT, R/W: 8-bit load value. A write of N>0 starts the INT countdown. A write of 0 disarms (INT FSM -> IDLE, int_n=1).
  - +1 NMI_CNT, R/W: same semantics for the NMI FSM.
  - +2 VECTOR, R/W: IM2 vector byte.
  - +3 STATUS, R/W1C.
    - Read bits: [0]=int asserted, [1]=nmi pulse active, [2]=int counting, [3]=nmi counting, [7:4]=ack_cnt.
    - Write bit0=1 clears a pending int (ASSERT -> IDLE). Write bit4=1 zeroes ack_cnt. Other bits are ignored.
- INT FSM (IDLE, COUNT, ASSERT):
  - IDLE -> COUNT on a write to INT_CNT with N>0; the down-counter loads N on that edge.
  - COUNT: the counter decrements each clk. On reaching 0 the FSM goes to ASSERT. int_n goes low exactly N posedges after the write edge and is registered, with no glitches.
  - ASSERT: int_n held low.
    - -> IDLE on the first posedge with intack=1; ack_cnt increments, wrapping 15->0.
    - -> IDLE on a STATUS bit0 clear.
  - A write to INT_CNT in any state restarts: N>0 -> COUNT with int_n released; N=0 -> IDLE. Any pending interrupt is dropped.
  - intack and a STATUS clear on the same edge: -> IDLE, and ack_cnt still increments.
- NMI FSM (IDLE, COUNT, PULSE):
  - IDLE/COUNT behave as in the INT FSM.
  - On the count reaching 0 the FSM enters PULSE. nmi_n is low for exactly NMI_WIDTH clks, then the FSM returns to IDLE.
  - There is no acknowledge.
  - A write to NMI_CNT during PULSE is captured and restarts COUNT after the pulse completes; the pulse is never truncated.
- INT and NMI are fully independent and may both be active in the same cycle.
- Mid-operation reset_n low: everything returns to reset values immediately, without waiting for clk.

Optional Feature:
- Macro: ENV_INT_AUTO_REARM_EN.
- Defined:
  - The last nonzero INT_CNT value is held in a reload register.
  - On leaving ASSERT via intack, the FSM goes straight to COUNT, reloaded, giving periodic interrupts.
  - A STATUS clear or an INT_CNT=0 write still goes to IDLE and stops the rearm.
- Undefined: one-shot only; intack -> IDLE, and no reload register is built.

Test Plan:
- Reset held 20 clks with bus idle -> int_n=1, nmi_n=1, DI=zz. Read of STATUS after release returns 8'h00.
- OUT (0x90),5 -> int_n low exactly 5 posedges after the write edge. The IM2 ack cycle with VECTOR=8'h40 returns DI=8'h40; int_n rises on the first intack posedge; STATUS[7:4]=1.
- OUT (0x91),3 with NMI_WIDTH=4 -> nmi_n low for exactly 4 clks, starting 3 posedges after the write. STATUS[1] reads 1 during the pulse and 0 after.
- INT pending, then OUT (0x93),0x01 -> int_n=1 next posedge, no vector driven on the next M1. OUT (0x90),0 while COUNT=2 -> no interrupt ever.
- A write strobe held low 3 clks with data 8'h02 -> a single load, with int_n low 2 posedges after the first strobe edge. A reset pulse mid-COUNT -> int_n stays 1.
- With ENV_INT_AUTO_REARM_EN, OUT (0x90),10 plus an immediate ack each time -> interrupts every 10+ack clks. Over 17 acks ack_cnt reads back 1 (wraps 15->0, then +1).
